// File: rtl/serial_tx_buf.sv
// serial_tx_buf: configurable double-buffered asynchronous serial transmitter
module serial_tx_buf #(
    parameter int DATA_BITS    = 8,
    parameter int BIT_DELAY    = 3,
    parameter int COUNTER_BITS = 2,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 dataLoad,
    output logic                 serialOut,
    output logic                 ready,
    output logic                 busy
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    state_t                  state_q, state_d;
    logic [COUNTER_BITS-1:0] cnt_q, cnt_d;
    logic [3:0]              idx_q, idx_d;
    logic [DATA_BITS-1:0]    shift_q, shift_d, hold_q, hold_d, next_word;
    logic                    par_q, par_d, hold_full_q, hold_full_d;
    logic                    out_q, out_d, busy_q, busy_d;
    logic                    cnt_last, done, accept, start_new;

    assign cnt_last  = cnt_q == COUNTER_BITS'(BIT_DELAY - 1);
    assign done      = state_q == S_STOP && cnt_last && idx_q == 4'(STOP_BITS - 1);
    assign accept    = dataLoad && !hold_full_q;
    assign start_new = (state_q == S_IDLE || done) && (hold_full_q || accept);
    assign next_word = hold_full_q ? hold_q : data;

    // Frame sequencing, holding-register handoff and next line value
    always_comb begin
        state_d     = state_q;
        cnt_d       = (state_q == S_IDLE || cnt_last) ? '0 : cnt_q + COUNTER_BITS'(1);
        idx_d       = idx_q;
        shift_d     = shift_q;
        par_d       = par_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (accept && !start_new) begin
            hold_d      = data;
            hold_full_d = 1'b1;
        end
        if (start_new) begin
            state_d     = S_START;
            cnt_d       = '0;
            idx_d       = '0;
            shift_d     = next_word;
            par_d       = (^next_word) ^ (PARITY == 2);
            hold_full_d = 1'b0;
        end else if (cnt_last && state_q != S_IDLE) begin
            case (state_q)
                S_START: begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
                S_DATA: begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q == 4'(DATA_BITS - 1) ? '0 : idx_q + 4'd1;
                    if (idx_q == 4'(DATA_BITS - 1))
                        state_d = PARITY != 0 ? S_PAR : S_STOP;
                end
                S_PAR: begin
                    state_d = S_STOP;
                    idx_d   = '0;
                end
                S_STOP: begin
                    state_d = done ? S_IDLE : S_STOP;
                    idx_d   = done ? '0 : idx_q + 4'd1;
                end
                default: state_d = S_IDLE;
            endcase
        end
        out_d  = state_d == S_START ? 1'b0 :
                 state_d == S_DATA  ? shift_d[0] :
                 state_d == S_PAR   ? par_d : 1'b1;
        busy_d = state_d != S_IDLE;
    end

    // State register; reset drops any frame and pending word and idles the line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            out_q       <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            out_q       <= out_d;
            busy_q      <= busy_d;
        end
    end

    assign serialOut = out_q;
    assign ready     = !hold_full_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_serial_tx_buf.sv
// tb_serial_tx_buf: three configurations driven together, checked against a per-cycle line model
module tb_serial_tx_buf;
    logic       clk, rst, load;
    logic [8:0] din;
    logic [2:0] so, rd, bz;
    int         n_vec = 0;
    int         n_err = 0;

    int db [3] = '{8, 7, 8};
    int pa [3] = '{0, 1, 2};
    int sb [3] = '{1, 1, 2};
    int bd [3] = '{3, 3, 4};
    bit q  [3][$];

    serial_tx_buf #(.DATA_BITS(8), .BIT_DELAY(3), .COUNTER_BITS(2), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset(rst), .data(din[7:0]), .dataLoad(load),
        .serialOut(so[0]), .ready(rd[0]), .busy(bz[0]));
    serial_tx_buf #(.DATA_BITS(7), .BIT_DELAY(3), .COUNTER_BITS(2), .PARITY(1), .STOP_BITS(1)) dut1 (
        .clk(clk), .reset(rst), .data(din[6:0]), .dataLoad(load),
        .serialOut(so[1]), .ready(rd[1]), .busy(bz[1]));
    serial_tx_buf #(.DATA_BITS(8), .BIT_DELAY(4), .COUNTER_BITS(2), .PARITY(2), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(rst), .data(din[7:0]), .dataLoad(load),
        .serialOut(so[2]), .ready(rd[2]), .busy(bz[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int fl(int i);
        return (1 + db[i] + (pa[i] != 0 ? 1 : 0) + sb[i]) * bd[i];
    endfunction

    // Expected line level for every cycle of one frame, appended behind whatever is queued
    function automatic void push_frame(int i, logic [8:0] w);
        bit bits[$];
        int ones = 0;
        bits.push_back(1'b0);
        for (int k = 0; k < db[i]; k++) begin
            bits.push_back(w[k]);
            ones += int'(w[k]);
        end
        if (pa[i] != 0) bits.push_back(pa[i] == 1 ? (ones % 2 == 1) : (ones % 2 == 0));
        for (int k = 0; k < sb[i]; k++) bits.push_back(1'b1);
        foreach (bits[k]) repeat (bd[i]) q[i].push_back(bits[k]);
    endfunction

    function automatic void chk(string nm, int i, logic act, logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cfg%0d at %0t: got %b, want %b", nm, i, $time, act, exp);
        end
    endfunction

    // A load is taken when fewer than one full frame is still queued; then compare and pop one cycle
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) q[i].delete();
            else if (load && q[i].size() < fl(i)) push_frame(i, din);
            chk("ready", i, rd[i], q[i].size() <= fl(i));
            if (q[i].size() > 0) begin
                chk("serialOut", i, so[i], q[i][0]);
                chk("busy", i, bz[i], 1'b1);
                void'(q[i].pop_front());
            end else begin
                chk("serialOut_idle", i, so[i], 1'b1);
                chk("busy_idle", i, bz[i], 1'b0);
            end
        end
    end

    task automatic cyc(input logic l, input logic [8:0] d);
        load = l;
        din  = d;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 9'($urandom));
    endtask

    initial begin
        rst  = 1'b1;
        load = 1'b0;
        din  = '0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        idle(2);
        cyc(1'b1, 9'h065);
        idle(40);
        cyc(1'b1, 9'h065);
        idle(4);
        cyc(1'b1, 9'h0A0);
        idle(75);
        cyc(1'b1, 9'h011);
        cyc(1'b1, 9'h022);
        repeat (40) cyc(1'b1, 9'h033);
        idle(110);
        cyc(1'b1, 9'h043);
        idle(60);
        cyc(1'b1, 9'h007);
        idle(60);
        cyc(1'b1, 9'h065);
        cyc(1'b1, 9'h012);
        idle(10);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
        idle(2);
        cyc(1'b1, 9'h0FF);
        idle(60);
        repeat (300) cyc($urandom_range(0, 9) < 3, 9'($urandom));
        idle(120);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
